fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults, constants and the queue-entry layout for the instruction fetch unit.
package fetch_pkg;
  localparam int          ADDR_W_DEF   = 64;
  localparam int          INSTR_W_DEF  = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam int          INSTR_BYTES  = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic bit is_pow2(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; reads zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q < (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= wdata;
  end

  // Storage is never reset, so hide stale contents while empty.
  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, one-deep in-flight tracking,
// redirect squash, and a prefetch queue feeding the consumer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [ADDR_W-1:0]      out_pc_plus4,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("fetch_unit: DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, infl_pc_q, infl_pc_d, target_aligned;
  logic              infl_q, infl_d, squash_q, squash_d;
  logic              push, pop;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;

  always_comb begin
    target_aligned = redirect_target & ~ADDR_W'(INSTR_BYTES - 1);
    // Occupancy counts the outstanding response so the queue can never overflow.
    imem_req  = !reset && !redirect_valid && ((count + CW'(infl_q)) < CW'(DEPTH));
    imem_addr = fetch_pc_q;
    push      = infl_q && !squash_q && !redirect_valid && !reset;
    pop       = out_valid && out_ready && !redirect_valid && !reset;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = target_aligned;
    else if (imem_req)   fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    infl_d    = imem_req;
    infl_pc_d = imem_req ? fetch_pc_q : infl_pc_q;
    squash_d  = redirect_valid && infl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      squash_q   <= squash_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({infl_pc_q, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign out_valid    = (count != '0);
  assign out_pc       = head[EW-1:INSTR_W];
  assign out_instr    = head[INSTR_W-1:0];
  assign out_pc_plus4 = out_valid ? (out_pc + ADDR_W'(INSTR_BYTES)) : '0;
  assign q_count      = count;
endmodule
